poly_note_synth: RTL and testbench
==================================

# poly_note_synth

Parametrised polyphonic square-wave note synthesizer. It accepts note-on and note-off commands over a valid/ready interface and allocates them to `NUM_VOICES` oscillators, reusing a voice that already holds the note and stealing round-robin when all voices are busy. Active voices are mixed by count, scaled by volume, and rendered as a single PWM bit. It sits between the keyboard/button front end and the mono audio-jack driver, which maps `pwm_out` to AUD_PWM.

## Interface
- `NUM_VOICES`, 4: number of oscillators, 1..8.
- `NUM_NOTES`, 12: notes per octave (C..B).
- `OCT_W`, 3: octave field width; octave n divides the C1-based period by 2^n.
- `VOL_W`, 4: volume width.
- `PER_W`, 32: period counter width.
- `clk` in 1: 100 MHz system clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_on` in 1: 1 = note-on, 0 = note-off.
- `cmd_note` in 4: note index 0..NUM_NOTES-1 (0 = C).
- `cmd_octave` in OCT_W: octave number.
- `volume` in VOL_W: master volume; 0 = silent.
- `voice_active` out NUM_VOICES: per-voice busy flags.
- `pwm_out` out 1: mixed PWM; 1 = drive high.

## Operation
- Period: `period = C1_PERIOD[note] >> octave`, where C1_PERIOD = 3057805, 2886184, 2724194, 2571298, 2426982, 2290765, 2162195, 2040840, 1926296, 1818182, 1716135, 1619816. `half = period >> 1`.
- Command FSM has three states:
  - IDLE: `cmd_ready` = 1. On `cmd_valid & cmd_ready`, latch `cmd_on`, `cmd_note`, `cmd_octave` and go to SEARCH.
  - SEARCH: register a match vector (active and same note and same octave) and a free vector (inactive). Go to APPLY.
  - APPLY: write voice state and return to IDLE.
- Note-on:
  - If any voice matches, retrigger the lowest-index match: counter = 0, phase = 0.
  - Otherwise, if any voice is free, load the lowest-index free voice.
  - Otherwise, steal voice `steal_ptr` and advance `steal_ptr` modulo NUM_VOICES.
  - A loaded voice sets active = 1, counter = 0, phase = 0, and stores note, octave and half.
- Note-off: every matching voice gets active = 0 and phase = 0. With no match, the command is consumed with no effect.
- `cmd_note >= NUM_NOTES`: the command is accepted, passes through all states, and changes nothing.
- Oscillator, per active voice, every clk: if counter == half-1, set counter = 0 and toggle phase; otherwise increment counter. Inactive voices hold counter = 0 and phase = 0.
- Mixer:
  - `level = popcount(phase & active) * vol_q`, with width clog2(NUM_VOICES*(2^VOL_W-1)+1).
  - `PWM_MAX = NUM_VOICES*(2^VOL_W-1)`.
  - Carrier counter `pc` runs 0..PWM_MAX-1 and wraps.
  - `pwm_out` = (pc < level), registered.
  - `vol_q` samples `volume` only when pc == PWM_MAX-1, so each frame uses a glitch-free volume.

## Timing
- Reset values: `cmd_ready` = 1, FSM = IDLE, `voice_active` = 0, all phases and counters = 0, `steal_ptr` = 0, pc = 0, `vol_q` = 0, `pwm_out` = 0.
- Accept edge T: `cmd_ready` is 0 during T+1 and T+2.
- `voice_active` and voice state are updated at edge T+2. `cmd_ready` is 1 again after T+2. Maximum rate is 1 command per 3 cycles.
- A retriggered or newly loaded voice first toggles phase `half` cycles after T+2.
- `pwm_out` lags `level` by 1 cycle. A new volume takes effect at the next frame start, at most PWM_MAX cycles later.
- `cmd_valid` may drop while `cmd_ready` = 0; commands are never queued.
- Reset assertion mid-command aborts it with no voice change and restores all reset values immediately.

## Structure
- Package `synth_pkg`: the C1_PERIOD constant array, NUM_NOTES, and FSM state enum (IDLE, SEARCH, APPLY).
- Sub-module `voice_osc`: holds counter, phase, active, note, octave and half. Load/clear strobes come from the FSM. Instantiated NUM_VOICES times in a generate loop.
- Top level: FSM, priority encoders (lowest-set-bit, reused for match and free vectors), `steal_ptr`, popcount mixer, PWM carrier.

## Test plan
- Reset: hold `resetn` = 0 with `cmd_valid` = 1 → `cmd_ready` = 1, `voice_active` = 0, `pwm_out` = 0 throughout. Release → the command is accepted on the first edge.
- Note-on A (9), octave 4 → `voice_active` = 0001 at T+2. Voice 0 phase toggles every 56818 cycles (period 113636).
- Repeat the same note-on → still 0001; the counter restarts at 0. Then note-on C3 → 0011. Note-off A4 → 0010. Note-off for an absent note → 0010, and `cmd_ready` returns after 3 cycles.
- Steal (NUM_VOICES = 4): five distinct note-ons → 1111, with the 5th note in voice 0. A 6th distinct note-on → lands in voice 1.
- Mixer: volume = 15, one voice with phase = 1 → `pwm_out` high 15 of 60 carrier cycles. Two voices high → 30 of 60. Volume changed mid-frame → old duty until pc wraps.
- Invalid note `cmd_note` = 13 with `cmd_on` = 1 → accepted; no change to `voice_active` or `steal_ptr`.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants for the polyphonic note synthesizer: C1 periods in clk cycles,
// the command FSM encoding and a lowest-set-bit helper used for voice allocation.
package synth_pkg;

  localparam int NUM_NOTES = 12;

  // Periods of octave-1 notes C..B at 100 MHz; higher octaves shift right.
  localparam logic [31:0] C1_PERIOD [NUM_NOTES] = '{
    32'd3057805, 32'd2886184, 32'd2724194, 32'd2571298,
    32'd2426982, 32'd2290765, 32'd2162195, 32'd2040840,
    32'd1926296, 32'd1818182, 32'd1716135, 32'd1619816
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    APPLY  = 2'd2
  } fsm_state_t;

  function automatic logic [2:0] lowest_set(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/poly_note_synth_if.sv
// Note command channel: valid/ready handshake carrying on/off, note and octave.
interface poly_note_synth_if #(
  parameter int OCT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_on;
  logic [3:0]       cmd_note;
  logic [OCT_W-1:0] cmd_octave;

  modport master (output cmd_valid, output cmd_on, output cmd_note, output cmd_octave,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_on, input  cmd_note, input  cmd_octave,
                  output cmd_ready);
endinterface

// File: rtl/voice_osc.sv
// One square-wave voice: a half-period counter toggling phase while active.
module voice_osc #(
  parameter int OCT_W = 3,
  parameter int PER_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [3:0]       i_note,
  input  logic [OCT_W-1:0] i_octave,
  input  logic [PER_W-1:0] i_half,
  output logic             o_active,
  output logic             o_phase,
  output logic [3:0]       o_note,
  output logic [OCT_W-1:0] o_octave
);

  logic             r_active;
  logic             r_phase;
  logic [PER_W-1:0] r_cnt;
  logic [PER_W-1:0] r_half;
  logic [3:0]       r_note;
  logic [OCT_W-1:0] r_octave;
  logic [PER_W-1:0] w_half_m1;

  assign w_half_m1 = r_half - PER_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_active <= 1'b0;
      r_phase  <= 1'b0;
      r_cnt    <= '0;
      r_half   <= '0;
      r_note   <= '0;
      r_octave <= '0;
    end else if (i_load) begin
      // Retrigger and fresh load are the same operation: restart from phase 0.
      r_active <= 1'b1;
      r_phase  <= 1'b0;
      r_cnt    <= '0;
      r_half   <= i_half;
      r_note   <= i_note;
      r_octave <= i_octave;
    end else if (i_clear || !r_active) begin
      r_active <= 1'b0;
      r_phase  <= 1'b0;
      r_cnt    <= '0;
    end else if (r_cnt == w_half_m1) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + PER_W'(1);
    end
  end

  assign o_active = r_active;
  assign o_phase  = r_phase;
  assign o_note   = r_note;
  assign o_octave = r_octave;

endmodule

// File: rtl/poly_note_synth.sv
// Polyphonic square-wave synth: command FSM allocates notes to voices, the active
// phases are counted, scaled by a frame-latched volume and rendered as PWM.
module poly_note_synth
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NUM_NOTES  = synth_pkg::NUM_NOTES,
  parameter int OCT_W      = 3,
  parameter int VOL_W      = 4,
  parameter int PER_W      = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  poly_note_synth_if.slave      cmd,
  input  logic [VOL_W-1:0]      volume,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  pwm_out
);

  localparam int PWM_MAX = NUM_VOICES * ((2 ** VOL_W) - 1);
  localparam int LVL_W   = $clog2(PWM_MAX + 1);

  fsm_state_t            r_state;
  logic                  r_on;
  logic [3:0]            r_note;
  logic [OCT_W-1:0]      r_octave;
  logic [NUM_VOICES-1:0] r_match;
  logic [NUM_VOICES-1:0] r_free;
  logic [2:0]            r_steal;

  logic [NUM_VOICES-1:0] w_active, w_phase, w_match, w_load, w_clear;
  logic [3:0]            w_note   [NUM_VOICES];
  logic [OCT_W-1:0]      w_octave [NUM_VOICES];
  logic                  w_note_ok, w_do_load;
  logic [2:0]            w_sel;
  logic [31:0]           w_period;
  logic [PER_W-1:0]      w_half;

  assign w_note_ok = (int'(r_note) < NUM_NOTES);
  assign w_period  = w_note_ok ? C1_PERIOD[r_note] : 32'd0;
  assign w_half    = PER_W'((w_period >> r_octave) >> 1);

  assign cmd.cmd_ready = (r_state == IDLE);
  assign voice_active  = w_active;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_on     <= 1'b0;
      r_note   <= '0;
      r_octave <= '0;
      r_match  <= '0;
      r_free   <= '0;
      r_steal  <= '0;
    end else begin
      case (r_state)
        IDLE: if (cmd.cmd_valid) begin
          r_on     <= cmd.cmd_on;
          r_note   <= cmd.cmd_note;
          r_octave <= cmd.cmd_octave;
          r_state  <= SEARCH;
        end
        SEARCH: begin
          r_match <= w_match;
          r_free  <= ~w_active;
          r_state <= APPLY;
        end
        APPLY: begin
          // The steal pointer only moves when a note-on actually stole a voice.
          if (r_on && w_note_ok && !(|r_match) && !(|r_free))
            r_steal <= (r_steal == 3'(NUM_VOICES - 1)) ? 3'd0 : r_steal + 3'd1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_do_load = 1'b0;
    w_sel     = r_steal;
    w_clear   = '0;
    if (r_state == APPLY && w_note_ok) begin
      if (r_on) begin
        w_do_load = 1'b1;
        if (|r_match)     w_sel = lowest_set(8'(r_match));
        else if (|r_free) w_sel = lowest_set(8'(r_free));
      end else begin
        w_clear = r_match;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign w_load[gi]  = w_do_load && (w_sel == 3'(gi));
      assign w_match[gi] = w_active[gi] && (w_note[gi] == r_note) && (w_octave[gi] == r_octave);

      voice_osc #(.OCT_W(OCT_W), .PER_W(PER_W)) u_osc (
        .clk      (clk),
        .resetn   (resetn),
        .i_load   (w_load[gi]),
        .i_clear  (w_clear[gi]),
        .i_note   (r_note),
        .i_octave (r_octave),
        .i_half   (w_half),
        .o_active (w_active[gi]),
        .o_phase  (w_phase[gi]),
        .o_note   (w_note[gi]),
        .o_octave (w_octave[gi])
      );
    end
  endgenerate

  logic [LVL_W-1:0] r_pc;
  logic [VOL_W-1:0] r_vol_q;
  logic             r_pwm;
  logic [LVL_W-1:0] w_pop;
  logic [LVL_W-1:0] w_level;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_pop = w_pop + LVL_W'(w_phase[i] & w_active[i]);
    end
    w_level = w_pop * LVL_W'(r_vol_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc    <= '0;
      r_vol_q <= '0;
      r_pwm   <= 1'b0;
    end else begin
      r_pwm <= (r_pc < w_level);
      // Volume is sampled only at the frame boundary so a frame never mixes two duties.
      if (r_pc == LVL_W'(PWM_MAX - 1)) begin
        r_pc    <= '0;
        r_vol_q <= volume;
      end else begin
        r_pc <= r_pc + LVL_W'(1);
      end
    end
  end

  assign pwm_out = r_pwm;

endmodule

// File: tb/tb_poly_note_synth.sv
// Directed bench for poly_note_synth: allocation, retrigger, stealing, mixer duty and reset.
module tb_poly_note_synth;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] volume;
  logic [3:0] voice_active;
  logic       pwm_out;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  poly_note_synth_if #(.OCT_W(3)) cmd_if ();

  poly_note_synth #(
    .NUM_VOICES (4),
    .NUM_NOTES  (12),
    .OCT_W      (3),
    .VOL_W      (4),
    .PER_W      (32)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cmd          (cmd_if),
    .volume       (volume),
    .voice_active (voice_active),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0d", tag, got);
    end
  endtask

  // Called right after the accept edge T; returns at the negedge after T+2.
  task automatic finish_cmd(input string tag, input logic [3:0] exp_act);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    check_val({tag, "_rdy_t1"}, 32'(cmd_if.cmd_ready), 0);
    @(negedge clk);
    check_val({tag, "_rdy_t2"}, 32'(cmd_if.cmd_ready), 0);
    @(negedge clk);
    check_val({tag, "_rdy_back"}, 32'(cmd_if.cmd_ready), 1);
    check_val({tag, "_act"}, 32'(voice_active), 32'(exp_act));
  endtask

  task automatic send_cmd(input string tag, input logic on, input logic [3:0] note,
                          input logic [2:0] oct, input logic [3:0] exp_act);
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_on     = on;
    cmd_if.cmd_note   = note;
    cmd_if.cmd_octave = oct;
    @(posedge clk);
    finish_cmd(tag, exp_act);
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
  endtask

  int t_a4, t_b7, hi, found;

  initial begin
    volume            = 4'd15;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_on     = 1'b1;
    cmd_if.cmd_note   = 4'd9;
    cmd_if.cmd_octave = 3'd4;

    repeat (4) begin
      @(negedge clk);
      check_val("rst_rdy", 32'(cmd_if.cmd_ready), 1);
      check_val("rst_act", 32'(voice_active), 0);
      check_val("rst_pwm", 32'(pwm_out), 0);
    end
    resetn = 1'b1;
    @(posedge clk);
    finish_cmd("on_A4", 4'b0001);

    // Retrigger: A4 half period is 56818, counted from this command's apply edge.
    send_cmd("retrig_A4", 1'b1, 4'd9, 3'd4, 4'b0001);
    t_a4 = cyc;
    send_cmd("on_C3", 1'b1, 4'd0, 3'd3, 4'b0011);
    while (cyc < t_a4 + 56817) @(negedge clk);
    check_val("a4_phase_pre", 32'(dut.w_phase[0]), 0);
    @(negedge clk);
    check_val("a4_phase_post", 32'(dut.w_phase[0]), 1);
    count_high(60, hi);
    check_val("duty_one_voice", 32'(hi), 15);

    // B7 half period: (1619816 >> 7) >> 1 = 6327.
    send_cmd("on_B7", 1'b1, 4'd11, 3'd7, 4'b0111);
    t_b7 = cyc;
    while (cyc < t_b7 + 6326) @(negedge clk);
    check_val("b7_phase_pre", 32'(dut.w_phase[2]), 0);
    @(negedge clk);
    check_val("b7_phase_post", 32'(dut.w_phase[2]), 1);
    count_high(60, hi);
    check_val("duty_two_voice", 32'(hi), 30);

    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(negedge clk);
      if (dut.r_pc == 6'd5) found = 1;
    end
    check_val("pc_sync", 32'(found), 1);
    volume = 4'd5;
    count_high(55, hi);
    check_val("duty_old_frame", 32'(hi), 25);
    count_high(60, hi);
    check_val("duty_new_frame", 32'(hi), 10);

    send_cmd("off_A4", 1'b0, 4'd9, 3'd4, 4'b0110);
    send_cmd("off_absent", 1'b0, 4'd2, 3'd5, 4'b0110);
    send_cmd("off_C3", 1'b0, 4'd0, 3'd3, 4'b0100);
    send_cmd("off_B7", 1'b0, 4'd11, 3'd7, 4'b0000);

    send_cmd("on_E2", 1'b1, 4'd4, 3'd2, 4'b0001);
    send_cmd("on_F2", 1'b1, 4'd5, 3'd2, 4'b0011);
    send_cmd("on_G2", 1'b1, 4'd7, 3'd2, 4'b0111);
    send_cmd("on_A2", 1'b1, 4'd9, 3'd2, 4'b1111);
    send_cmd("steal_B2", 1'b1, 4'd11, 3'd2, 4'b1111);
    send_cmd("off_E2_gone", 1'b0, 4'd4, 3'd2, 4'b1111);
    send_cmd("steal_C2", 1'b1, 4'd0, 3'd2, 4'b1111);
    send_cmd("off_F2_gone", 1'b0, 4'd5, 3'd2, 4'b1111);
    send_cmd("on_invalid", 1'b1, 4'd13, 3'd2, 4'b1111);
    send_cmd("off_B2_v0", 1'b0, 4'd11, 3'd2, 4'b1110);
    send_cmd("off_C2_v1", 1'b0, 4'd0, 3'd2, 4'b1100);
    send_cmd("on_D2", 1'b1, 4'd2, 3'd2, 4'b1101);
    send_cmd("on_Ds2", 1'b1, 4'd3, 3'd2, 4'b1111);
    send_cmd("steal_E3", 1'b1, 4'd4, 3'd3, 4'b1111);
    send_cmd("off_G2_gone", 1'b0, 4'd7, 3'd2, 4'b1111);
    send_cmd("off_E3_v2", 1'b0, 4'd4, 3'd3, 4'b1011);

    // Reset while the FSM is in SEARCH must abort the command immediately.
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_on     = 1'b1;
    cmd_if.cmd_note   = 4'd6;
    cmd_if.cmd_octave = 3'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check_val("midrst_rdy", 32'(cmd_if.cmd_ready), 1);
    check_val("midrst_act", 32'(voice_active), 0);
    check_val("midrst_pwm", 32'(pwm_out), 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check_val("postrst_act", 32'(voice_active), 0);
    check_val("postrst_rdy", 32'(cmd_if.cmd_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
